// File: rtl/andor_share_ctrl.sv
// andor_share_ctrl
// Time-shares a single AndOr unit (X = A & B, Y = B | C) among NREQ requesters.
// A round-robin arbiter picks one requester per IDLE visit, its operand bits are
// registered onto the shared unit, the controller waits SETTLE cycles so the unit's
// propagation delay has elapsed, then samples X/Y and presents them together with
// the requester ID on a valid/ready response channel.

module andor_share_ctrl #(
    parameter int NREQ   = 4,
    parameter int SETTLE = 3,
    parameter int IDW    = $clog2(NREQ)
) (
    input  bit            clk,
    input  bit            rst,
    input  bit [NREQ-1:0] req_valid,
    input  bit [NREQ-1:0] req_a,
    input  bit [NREQ-1:0] req_b,
    input  bit [NREQ-1:0] req_c,
    output bit [NREQ-1:0] req_ready,
    output bit            op_a,
    output bit            op_b,
    output bit            op_c,
    input  bit            op_x,
    input  bit            op_y,
    output bit            rsp_valid,
    input  bit            rsp_ready,
    output bit [IDW-1:0]  rsp_id,
    output bit            rsp_x,
    output bit            rsp_y,
    output bit            busy
);

    // Settle counter counts SETTLE-1 down to 0, so it needs one bit beyond log2.
    localparam int CW = $clog2(SETTLE) + 1;
    // Candidate index sums need one extra bit before the modulo-NREQ wrap.
    localparam int SW = IDW + 1;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SETTLE_WAIT = 2'd1,
        RESP        = 2'd2
    } StateT;

    StateT           r_state;
    logic [IDW-1:0]  r_ptr;
    logic [CW-1:0]   r_cnt;
    logic            r_opA;
    logic            r_opB;
    logic            r_opC;
    logic            r_rspValid;
    logic [IDW-1:0]  r_rspId;
    logic            r_rspX;
    logic            r_rspY;
    logic            r_busy;

    logic [SW-1:0]   w_candSum [NREQ];
    logic [IDW-1:0]  w_cand    [NREQ];
    logic            w_grantFound;
    logic [IDW-1:0]  w_grantIdx;
    logic [NREQ-1:0] w_grantOneHot;
    logic [IDW-1:0]  w_nextPtr;
    logic            w_grantNow;

    // Candidate k is the requester k positions above the round-robin pointer,
    // wrapped explicitly so non-power-of-two NREQ never indexes past NREQ-1.
    for (genvar k = 0; k < NREQ; k++) begin : g_cand
        assign w_candSum[k] = {1'b0, r_ptr} + SW'(k);
        assign w_cand[k]    = (w_candSum[k] >= SW'(NREQ)) ? IDW'(w_candSum[k] - SW'(NREQ))
                                                          : IDW'(w_candSum[k]);
    end

    // Pick the first valid requester at or above the pointer; scanning from the far
    // end downward lets the closest candidate overwrite the others.
    always_comb begin
        w_grantFound = 1'b0;
        w_grantIdx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[w_cand[k]]) begin
                w_grantFound = 1'b1;
                w_grantIdx   = w_cand[k];
            end
        end
    end

    // One-hot form of the winner, used for the accept strobe.
    always_comb begin
        w_grantOneHot = '0;
        if (w_grantFound) begin
            w_grantOneHot[w_grantIdx] = 1'b1;
        end
    end

    // Pointer moves just past the winner, wrapping from NREQ-1 back to 0.
    assign w_nextPtr  = (w_grantIdx == IDW'(NREQ - 1)) ? '0 : w_grantIdx + IDW'(1);

    // A grant is only issued from IDLE and never during a reset cycle, so the
    // strobe can never announce a transfer that the registers will not take.
    assign w_grantNow = (r_state == IDLE) && w_grantFound && !rst;
    assign req_ready  = w_grantNow ? w_grantOneHot : '0;

    // Sequencing FSM: grant and capture operands, hold them for the settle
    // interval, sample the shared unit, then hold the response until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_opA      <= 1'b0;
            r_opB      <= 1'b0;
            r_opC      <= 1'b0;
            r_rspValid <= 1'b0;
            r_rspId    <= '0;
            r_rspX     <= 1'b0;
            r_rspY     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grantFound) begin
                        r_opA   <= req_a[w_grantIdx];
                        r_opB   <= req_b[w_grantIdx];
                        r_opC   <= req_c[w_grantIdx];
                        r_rspId <= w_grantIdx;
                        r_ptr   <= w_nextPtr;
                        r_cnt   <= CW'(SETTLE - 1);
                        r_state <= SETTLE_WAIT;
                        r_busy  <= 1'b1;
                    end
                end
                SETTLE_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rspX     <= op_x;
                        r_rspY     <= op_y;
                        r_rspValid <= 1'b1;
                        r_state    <= RESP;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_rspValid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign op_a      = r_opA;
    assign op_b      = r_opB;
    assign op_c      = r_opC;
    assign rsp_valid = r_rspValid;
    assign rsp_id    = r_rspId;
    assign rsp_x     = r_rspX;
    assign rsp_y     = r_rspY;
    assign busy      = r_busy;

endmodule
